// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg: shared widths and the NOP encoding for the fetch stage.
package ifetch_stage_pkg;
  localparam int PC_SIZE          = 32;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int INST_MEM_DEPTH   = 256;
  localparam int INST_ADDR_SIZE   = 8;
  localparam logic [INSTRUCTION_SIZE-1:0] NOP_INSTRUCTION = 32'h0;
endpackage

// File: rtl/ifetch_stage_inst_memory.sv
// inst_memory: instruction RAM with a synchronous write port for the loader and a combinational read port.
module inst_memory #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: MIPS PC, next-PC priority select and IF/ID register.
// Define IF_FETCH_COUNT_EN to get a count of real instructions handed to decode.
module ifetch_stage
  import ifetch_stage_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_pipeline_enable,
  input  logic                        i_stall,
  input  logic                        i_flush,
  input  logic                        i_halt,
  input  logic                        i_jump,
  input  logic [PC_SIZE-1:0]          i_jump_addr,
  input  logic                        i_jr_jalr,
  input  logic [PC_SIZE-1:0]          i_jr_addr,
  input  logic                        i_branch_taken,
  input  logic [PC_SIZE-1:0]          i_branch_addr,
  input  logic                        i_mem_write_enable,
  input  logic [INST_ADDR_SIZE-1:0]   i_mem_write_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_mem_write_data,
  output logic [INSTRUCTION_SIZE-1:0] o_inst,
  output logic [PC_SIZE-1:0]          o_pc,
  output logic [PC_SIZE-1:0]          o_pc_current,
  output logic                        o_halted,
  output logic [31:0]                 o_fetch_count
);
  logic [PC_SIZE-1:0] pc_q, pc_d, npc_q, npc_d, pc_inc;
  logic [INSTRUCTION_SIZE-1:0] inst_q, inst_d, mem_rdata;
  logic halted_q, halted_d, redirect;
  inst_memory #(.DEPTH(INST_MEM_DEPTH), .ADDR_W(INST_ADDR_SIZE), .DATA_W(INSTRUCTION_SIZE)) u_mem (
    .clk_i   (i_clock),
    .we_i    (i_mem_write_enable),
    .waddr_i (i_mem_write_addr),
    .wdata_i (i_mem_write_data),
    .raddr_i (pc_q[INST_ADDR_SIZE-1:0]),
    .rdata_o (mem_rdata)
  );
  assign pc_inc   = pc_q + PC_SIZE'(1);
  assign redirect = i_jr_jalr | i_jump;
  // Non-flush NOP bubbles carry o_pc=0, the same as the reset bubble.
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    npc_d    = npc_q;
    halted_d = halted_q;
    if (halted_q || i_halt) begin
      halted_d = 1'b1;
      inst_d   = NOP_INSTRUCTION;
      npc_d    = '0;
    end else if (i_branch_taken) begin
      pc_d   = i_branch_addr;
      inst_d = NOP_INSTRUCTION;
      npc_d  = '0;
    end else if (!i_stall) begin
      pc_d   = i_jr_jalr ? i_jr_addr : i_jump ? i_jump_addr : pc_inc;
      inst_d = (redirect || i_flush) ? NOP_INSTRUCTION : mem_rdata;
      npc_d  = redirect ? '0 : pc_inc;
    end
  end
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) begin
      pc_q     <= '0;
      npc_q    <= '0;
      inst_q   <= NOP_INSTRUCTION;
      halted_q <= 1'b0;
    end else if (i_pipeline_enable) begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      inst_q   <= inst_d;
      halted_q <= halted_d;
    end
`ifdef IF_FETCH_COUNT_EN
  logic [31:0] cnt_q;
  logic fetch;
  assign fetch = i_pipeline_enable & ~halted_q & ~i_halt & ~i_branch_taken & ~i_stall & ~redirect & ~i_flush;
  always_ff @(posedge i_clock or negedge i_reset)
    if (!i_reset) cnt_q <= '0;
    else if (fetch) cnt_q <= cnt_q + 32'd1;
  assign o_fetch_count = cnt_q;
`else
  assign o_fetch_count = '0;
`endif
  assign o_inst       = inst_q;
  assign o_pc         = npc_q;
  assign o_pc_current = pc_q;
  assign o_halted     = halted_q;
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: table-driven vectors through a scoreboard queue, plus halt and async-reset sequences.
module tb_ifetch_stage;
  logic        i_clock = 0, i_reset = 0, i_pipeline_enable = 0;
  logic        i_stall = 0, i_flush = 0, i_halt = 0, i_jump = 0, i_jr_jalr = 0, i_branch_taken = 0;
  logic [31:0] i_jump_addr = 0, i_jr_addr = 0, i_branch_addr = 0;
  logic        i_mem_write_enable = 0;
  logic [7:0]  i_mem_write_addr = 0;
  logic [31:0] i_mem_write_data = 0;
  logic [31:0] o_inst, o_pc, o_pc_current, o_fetch_count;
  logic        o_halted;
  int n_checks = 0, n_fail = 0;

  ifetch_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_pipeline_enable(i_pipeline_enable),
    .i_stall(i_stall), .i_flush(i_flush), .i_halt(i_halt),
    .i_jump(i_jump), .i_jump_addr(i_jump_addr), .i_jr_jalr(i_jr_jalr), .i_jr_addr(i_jr_addr),
    .i_branch_taken(i_branch_taken), .i_branch_addr(i_branch_addr),
    .i_mem_write_enable(i_mem_write_enable), .i_mem_write_addr(i_mem_write_addr),
    .i_mem_write_data(i_mem_write_data),
    .o_inst(o_inst), .o_pc(o_pc), .o_pc_current(o_pc_current), .o_halted(o_halted),
    .o_fetch_count(o_fetch_count)
  );

  always #5 i_clock = ~i_clock;

  localparam logic [6:0] EN = 7'h40, ST = 7'h20, FL = 7'h10, HL = 7'h08, JP = 7'h04, JR = 7'h02, BR = 7'h01;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] jaddr, jraddr, baddr;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] e_inst, e_pc, e_pcc;
    logic        e_halt, chk_pc;
    int          e_cnt;
  } vec_t;

  vec_t tv[$];
  vec_t sb[$];

  function automatic vec_t mk(logic [6:0] ctl, logic [31:0] ja, logic [31:0] jra, logic [31:0] ba,
                              logic [31:0] ei, logic [31:0] ep, logic [31:0] epc, logic eh, logic cp, int ec);
    vec_t v;
    v.ctl = ctl; v.jaddr = ja; v.jraddr = jra; v.baddr = ba;
    v.we = 0; v.waddr = 0; v.wdata = 0;
    v.e_inst = ei; v.e_pc = ep; v.e_pcc = epc; v.e_halt = eh; v.chk_pc = cp; v.e_cnt = ec;
    return v;
  endfunction

  function automatic int cnt_exp(int c);
`ifdef IF_FETCH_COUNT_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    {i_pipeline_enable, i_stall, i_flush, i_halt, i_jump, i_jr_jalr, i_branch_taken} = v.ctl;
    i_jump_addr = v.jaddr; i_jr_addr = v.jraddr; i_branch_addr = v.baddr;
    i_mem_write_enable = v.we; i_mem_write_addr = v.waddr; i_mem_write_data = v.wdata;
  endtask

  task automatic compare(string tag, vec_t e);
    check({tag, " inst"}, o_inst, e.e_inst);
    if (e.chk_pc) check({tag, " pc"}, o_pc, e.e_pc);
    check({tag, " pc_current"}, o_pc_current, e.e_pcc);
    check({tag, " halted"}, {31'b0, o_halted}, {31'b0, e.e_halt});
    check({tag, " fetch_count"}, o_fetch_count, 32'(cnt_exp(e.e_cnt)));
  endtask

  task automatic load(logic [7:0] a, logic [31:0] d);
    @(negedge i_clock);
    i_mem_write_enable = 1; i_mem_write_addr = a; i_mem_write_data = d;
    @(posedge i_clock);
    #1 i_mem_write_enable = 0;
  endtask

  initial begin
    vec_t v, e;
    // Memory image written while the core is held in reset.
    load(8'h00, 32'h20010005); load(8'h01, 32'h20020007);
    load(8'h02, 32'h0);        load(8'h03, 32'h0);
    load(8'h04, 32'h11110004); load(8'h10, 32'hAAAA0010);
    load(8'h20, 32'hBBBB0020); load(8'h21, 32'hBBBB0021);
    load(8'h30, 32'hCCCC0030); load(8'hFF, 32'h777700FF);
    #1 compare("reset", mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0));

    tv.push_back(mk(EN,           0,     0, 0,     32'h20010005, 32'h1,   32'h1,     0, 1, 1));
    tv.push_back(mk(EN,           0,     0, 0,     32'h20020007, 32'h2,   32'h2,     0, 1, 2));
    tv.push_back(mk(EN|ST|FL,     0,     0, 0,     32'h20020007, 32'h2,   32'h2,     0, 1, 2));
    tv.push_back(mk(EN|ST|JP|JR,  32'h30, 32'h8, 0, 32'h20020007, 32'h2,   32'h2,     0, 1, 2));
    tv.push_back(mk(EN,           0,     0, 0,     32'h0,        32'h3,   32'h3,     0, 1, 3));
    tv.push_back(mk(EN|JP,        32'h10, 0, 0,    32'h0,        32'h0,   32'h10,    0, 0, 3));
    tv.push_back(mk(EN,           0,     0, 0,     32'hAAAA0010, 32'h11,  32'h11,    0, 1, 4));
    tv.push_back(mk(EN|JR|JP,     32'h30, 32'h4, 0, 32'h0,       32'h0,   32'h4,     0, 0, 4));
    tv.push_back(mk(EN|FL,        0,     0, 0,     32'h0,        32'h5,   32'h5,     0, 1, 4));
    v = mk(JP, 32'h40, 0, 0, 32'h0, 32'h5, 32'h5, 0, 1, 4);
    v.we = 1; v.waddr = 8'h05; v.wdata = 32'hDEADBEEF;
    tv.push_back(v);
    tv.push_back(mk(EN,           0,     0, 0,     32'hDEADBEEF, 32'h6,   32'h6,     0, 1, 5));
    tv.push_back(mk(EN|JP,        32'h105, 0, 0,   32'h0,        32'h0,   32'h105,   0, 0, 5));
    tv.push_back(mk(EN,           0,     0, 0,     32'hDEADBEEF, 32'h106, 32'h106,   0, 1, 6));
    tv.push_back(mk(EN|BR|ST|JP|JR, 32'h30, 32'h8, 32'h20, 32'h0, 32'h0,  32'h20,    0, 0, 6));
    tv.push_back(mk(EN,           0,     0, 0,     32'hBBBB0020, 32'h21,  32'h21,    0, 1, 7));
    v = mk(EN, 0, 0, 0, 32'hBBBB0021, 32'h22, 32'h22, 0, 1, 8);
    v.we = 1; v.waddr = 8'h21; v.wdata = 32'h99999999;
    tv.push_back(v);
    tv.push_back(mk(EN|JP,        32'hFFFFFFFF, 0, 0, 32'h0,     32'h0,   32'hFFFFFFFF, 0, 0, 8));
    tv.push_back(mk(EN,           0,     0, 0,     32'h777700FF, 32'h0,   32'h0,     0, 1, 9));
    tv.push_back(mk(EN,           0,     0, 0,     32'h20010005, 32'h1,   32'h1,     0, 1, 10));
    tv.push_back(mk(EN|HL,        0,     0, 0,     32'h0,        32'h0,   32'h1,     1, 0, 10));
    tv.push_back(mk(EN|JP,        32'h10, 0, 0,    32'h0,        32'h0,   32'h1,     1, 0, 10));
    tv.push_back(mk(EN|BR,        0,     0, 32'h20, 32'h0,       32'h0,   32'h1,     1, 0, 10));
    tv.push_back(mk(0,            0,     0, 0,     32'h0,        32'h0,   32'h1,     1, 0, 10));

    @(negedge i_clock) i_reset = 1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge i_clock);
      drive(tv[i]);
      sb.push_back(tv[i]);
      @(posedge i_clock);
      #1;
      e = sb.pop_front();
      compare($sformatf("vec%0d", i), e);
    end

    // Halted state survives ten more enabled edges with a jump requested.
    @(negedge i_clock);
    drive(mk(EN|JP, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h1, 1, 0, 10));
      @(posedge i_clock);
      #1;
      e = sb.pop_front();
      compare($sformatf("halt%0d", i), e);
    end

    // Asynchronous reset in the middle of a cycle.
    @(posedge i_clock);
    #2 i_reset = 0;
    #1 compare("async_reset", mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0));
    @(negedge i_clock);
    drive(mk(EN, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    i_reset = 1;
    sb.push_back(mk(0, 0, 0, 0, 32'h20010005, 32'h1, 32'h1, 0, 1, 1));
    @(posedge i_clock);
    #1;
    e = sb.pop_front();
    compare("post_reset", e);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
